// File: rtl/spatial_filter_pkg.sv
// spatial_filter_pkg: shared widths, identity kernel and line-state encoding for the 3x3 convolver
package spatial_filter_pkg;
    localparam int PIX_W   = 8;
    localparam int COEF_W  = 8;
    localparam int SHIFT_W = 4;
    localparam int WIN_N   = 9;
    localparam int ACC_W   = 21;
    localparam logic [WIN_N*COEF_W-1:0] IDENTITY_KERNEL = 72'h000000000100000000;
    typedef enum logic {IDLE_LINE = 1'b0, IN_LINE = 1'b1} line_state_t;
endpackage

// File: rtl/conv3x3_mac_pipe.sv
// conv3x3_mac_pipe: multiply, sum and shift/clamp a 3x3 window in three registered stages
module conv3x3_mac_pipe
    import spatial_filter_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIX_W,
    parameter int COEF_WIDTH  = COEF_W,
    parameter int SHIFT_WIDTH = SHIFT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIN_N*PIXEL_WIDTH-1:0] win,
    input  logic                         win_valid,
    input  logic [WIN_N*COEF_WIDTH-1:0]  kernel,
    input  logic [SHIFT_WIDTH-1:0]       shift,
    output logic [PIXEL_WIDTH-1:0]       pixel,
    output logic                         pixel_valid
);
    localparam int PROD_WIDTH = PIXEL_WIDTH + COEF_WIDTH + 1;
    localparam int ACC_WIDTH  = ACC_W + PIXEL_WIDTH + COEF_WIDTH - PIX_W - COEF_W;
    localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((1 << PIXEL_WIDTH) - 1);

    logic signed [PROD_WIDTH-1:0] prod [WIN_N];
    logic signed [PROD_WIDTH-1:0] prod_q [WIN_N];
    logic signed [ACC_WIDTH-1:0]  sum, sum_q, shifted;
    logic [SHIFT_WIDTH-1:0]       shift_q1, shift_q2;
    logic                         valid_q1, valid_q2;
    logic [PIXEL_WIDTH-1:0]       pixel_next;

    for (genvar i = 0; i < WIN_N; i++) begin : g_mul
        assign prod[i] = PROD_WIDTH'($signed({1'b0, win[i*PIXEL_WIDTH +: PIXEL_WIDTH]}))
                       * PROD_WIDTH'($signed(kernel[i*COEF_WIDTH +: COEF_WIDTH]));
    end

    // sum the nine registered products and normalise/clamp the registered sum
    always_comb begin
        sum = '0;
        for (int i = 0; i < WIN_N; i++) sum = sum + ACC_WIDTH'(prod_q[i]);
        shifted = sum_q >>> shift_q2;
        pixel_next = (shifted < 0) ? '0 : (shifted > PIX_MAX) ? '1 : shifted[PIXEL_WIDTH-1:0];
    end

    // three pipeline stages; shift amount travels with its window so a kernel swap never splits one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q      <= '{default: '0};
            sum_q       <= '0;
            shift_q1    <= '0;
            shift_q2    <= '0;
            valid_q1    <= 1'b0;
            valid_q2    <= 1'b0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end else begin
            prod_q      <= prod;
            shift_q1    <= shift;
            valid_q1    <= win_valid;
            sum_q       <= sum;
            shift_q2    <= shift_q1;
            valid_q2    <= valid_q1;
            pixel_valid <= valid_q2;
            if (valid_q2) pixel <= pixel_next;
        end
    end
endmodule

// File: rtl/spatial_filter_conv3x3.sv
// spatial_filter_conv3x3: programmable 3x3 convolver with line-synchronous kernel updates
module spatial_filter_conv3x3
    import spatial_filter_pkg::*;
#(
    parameter int IMAGE_WIDTH = 512,
    parameter int PIXEL_WIDTH = PIX_W,
    parameter int COEF_WIDTH  = COEF_W,
    parameter int SHIFT_WIDTH = SHIFT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIN_N*PIXEL_WIDTH-1:0] i_pixel_data,
    input  logic                         i_pixel_data_valid,
    input  logic [WIN_N*COEF_WIDTH-1:0]  i_kernel,
    input  logic [SHIFT_WIDTH-1:0]       i_shift,
    input  logic                         i_kernel_load,
    output logic [PIXEL_WIDTH-1:0]       o_pixel_data,
    output logic                         o_pixel_data_valid,
    output logic                         o_line_done,
    output logic                         o_kernel_pending
);
    localparam int CNT_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int K_W   = WIN_N * COEF_WIDTH;
    localparam logic [K_W-1:0] ID_K = {{(WIN_N/2*COEF_WIDTH){1'b0}}, COEF_WIDTH'(1), {(WIN_N/2*COEF_WIDTH){1'b0}}};

    logic [K_W-1:0]         active_k, shadow_k;
    logic [SHIFT_WIDTH-1:0] active_sh, shadow_sh;
    logic [CNT_W-1:0]       out_cnt;
    line_state_t            state;

    assign o_line_done = o_pixel_data_valid && (out_cnt == CNT_W'(IMAGE_WIDTH - 1));

    conv3x3_mac_pipe #(
        .PIXEL_WIDTH(PIXEL_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_mac (
        .clk        (clk),
        .reset      (reset),
        .win        (i_pixel_data),
        .win_valid  (i_pixel_data_valid),
        .kernel     (active_k),
        .shift      (active_sh),
        .pixel      (o_pixel_data),
        .pixel_valid(o_pixel_data_valid)
    );

    // count output pixels within the line, wrapping on the last one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_cnt <= '0;
        else if (o_pixel_data_valid) out_cnt <= o_line_done ? '0 : out_cnt + 1'b1;
    end

    // loads apply at once between lines; inside a line they wait in the shadow until line end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE_LINE;
            active_k         <= ID_K;
            active_sh        <= '0;
            shadow_k         <= '0;
            shadow_sh        <= '0;
            o_kernel_pending <= 1'b0;
        end else if (state == IDLE_LINE || o_line_done) begin
            if (i_kernel_load) begin
                active_k  <= i_kernel;
                active_sh <= i_shift;
            end else if (o_kernel_pending) begin
                active_k  <= shadow_k;
                active_sh <= shadow_sh;
            end
            o_kernel_pending <= 1'b0;
            state            <= i_pixel_data_valid ? IN_LINE : IDLE_LINE;
        end else if (i_kernel_load) begin
            shadow_k         <= i_kernel;
            shadow_sh        <= i_shift;
            o_kernel_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spatial_filter_conv3x3.sv
// tb_spatial_filter_conv3x3: directed checks of arithmetic, latency, line timing, kernel swap and reset
module tb_spatial_filter_conv3x3;
    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] i_pixel_data, i_kernel;
    logic        i_pixel_data_valid, i_kernel_load;
    logic [3:0]  i_shift;
    logic [7:0]  o_pixel_data;
    logic        o_pixel_data_valid, o_line_done, o_kernel_pending;

    int total = 0;
    int bad   = 0;

    logic [71:0] s_win [24];
    logic [71:0] s_kern [24];
    logic        s_vld [24];
    logic        s_load [24];
    logic        s_done [24];
    logic        s_pend [24];
    logic [3:0]  s_shift [24];
    logic [7:0]  s_exp [24];
    logic [7:0]  last_pix;

    always #5 clk = ~clk;

    spatial_filter_conv3x3 #(.IMAGE_WIDTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_pixel_data      (i_pixel_data),
        .i_pixel_data_valid(i_pixel_data_valid),
        .i_kernel          (i_kernel),
        .i_shift           (i_shift),
        .i_kernel_load     (i_kernel_load),
        .o_pixel_data      (o_pixel_data),
        .o_pixel_data_valid(o_pixel_data_valid),
        .o_line_done       (o_line_done),
        .o_kernel_pending  (o_kernel_pending)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] b4(input logic [7:0] v);
        return {32'h0, v, 32'h0};
    endfunction

    task automatic drive(input logic [71:0] w, input logic v, input logic ld, input logic [71:0] k, input logic [3:0] sh);
        i_pixel_data       = w;
        i_pixel_data_valid = v;
        i_kernel_load      = ld;
        i_kernel           = k;
        i_shift            = sh;
    endtask

    task automatic clr_seq();
        for (int i = 0; i < 24; i++) begin
            s_win[i] = '0; s_kern[i] = '0; s_vld[i] = 1'b0; s_load[i] = 1'b0;
            s_done[i] = 1'b0; s_pend[i] = 1'b0; s_shift[i] = '0; s_exp[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive('0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_pixel", o_pixel_data, 8'h00);
        check("rst_valid", o_pixel_data_valid, 1'b0);
        check("rst_done", o_line_done, 1'b0);
        check("rst_pending", o_kernel_pending, 1'b0);
        reset = 1'b0;
        last_pix = 8'h00;
    endtask

    task automatic run_seq(input int n);
        for (int k = 0; k < n + 3; k++) begin
            logic ev;
            @(negedge clk);
            ev = (k >= 3) ? s_vld[k-3] : 1'b0;
            check($sformatf("valid@%0d", k), o_pixel_data_valid, ev);
            if (ev) last_pix = s_exp[k-3];
            check($sformatf("pixel@%0d", k), o_pixel_data, last_pix);
            check($sformatf("line_done@%0d", k), o_line_done, (k >= 3) ? (ev & s_done[k-3]) : 1'b0);
            check($sformatf("pending@%0d", k), o_kernel_pending, s_pend[k]);
            if (k < n) drive(s_win[k], s_vld[k], s_load[k], s_kern[k], s_shift[k]);
            else drive('0, 1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic run_one(input logic [71:0] w, input logic [7:0] exp);
        clr_seq();
        s_win[0] = w; s_vld[0] = 1'b1; s_exp[0] = exp;
        run_seq(1);
    endtask

    task automatic load_idle(input logic [71:0] k, input logic [3:0] sh);
        do_reset();
        @(negedge clk);
        drive('0, 1'b0, 1'b1, k, sh);
    endtask

    initial begin
        reset = 1'b0;
        drive('0, 1'b0, 1'b0, '0, '0);
        do_reset();
        run_one(b4(8'h5A), 8'h5A);
        load_idle({9{8'h01}}, 4'd3);
        run_one({9{8'h10}}, 8'h12);
        load_idle({9{8'h01}}, 4'd0);
        run_one({9{8'hFF}}, 8'hFF);
        load_idle(b4(8'hFF), 4'd0);
        run_one(b4(8'h80), 8'h00);
        load_idle(b4(8'h02), 4'd1);
        run_one(b4(8'h90), 8'h90);
        load_idle({32'h0, 8'h04, 24'h0, 8'hFF}, 4'd1);
        run_one({32'h0, 8'h20, 24'h0, 8'h10}, 8'h38);
        load_idle({9{8'h7F}}, 4'd15);
        run_one({9{8'hFF}}, 8'h08);
        load_idle({9{8'h80}}, 4'd0);
        run_one({9{8'hFF}}, 8'h00);

        do_reset();
        clr_seq();
        s_load[0] = 1'b1; s_kern[0] = b4(8'h02);
        s_win[0] = b4(8'h30); s_vld[0] = 1'b1; s_exp[0] = 8'h30;
        s_win[1] = b4(8'h30); s_vld[1] = 1'b1; s_exp[1] = 8'h60;
        run_seq(2);

        do_reset();
        clr_seq();
        for (int k = 0; k < 19; k++) begin
            if (k < 12 || k > 14) begin
                s_win[k] = b4(8'(k * 7 + 5)); s_vld[k] = 1'b1; s_exp[k] = 8'(k * 7 + 5);
            end
        end
        s_done[7] = 1'b1; s_done[18] = 1'b1;
        run_seq(19);

        do_reset();
        clr_seq();
        for (int k = 0; k < 19; k++) begin
            if (k < 8 || k > 10) begin
                s_win[k] = b4(8'h20); s_vld[k] = 1'b1; s_exp[k] = (k < 8) ? 8'h20 : 8'h60;
            end
        end
        s_load[3] = 1'b1; s_kern[3] = b4(8'h02);
        s_load[5] = 1'b1; s_kern[5] = b4(8'h03);
        for (int k = 4; k <= 10; k++) s_pend[k] = 1'b1;
        s_done[7] = 1'b1; s_done[18] = 1'b1;
        run_seq(19);

        do_reset();
        @(negedge clk) drive('0, 1'b0, 1'b1, b4(8'h02), 4'd0);
        @(negedge clk) drive(b4(8'h30), 1'b1, 1'b0, '0, 4'd0);
        @(negedge clk) drive(b4(8'h31), 1'b1, 1'b1, b4(8'h05), 4'd0);
        @(negedge clk) drive(b4(8'h32), 1'b1, 1'b0, '0, 4'd0);
        @(negedge clk) drive('0, 1'b0, 1'b0, '0, 4'd0);
        check("pre_rst_pixel", o_pixel_data, 8'h60);
        check("pre_rst_valid", o_pixel_data_valid, 1'b1);
        check("pre_rst_pending", o_kernel_pending, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_pixel", o_pixel_data, 8'h00);
        check("async_valid", o_pixel_data_valid, 1'b0);
        check("async_pending", o_kernel_pending, 1'b0);
        @(negedge clk) reset = 1'b0;
        last_pix = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_valid%0d", i), o_pixel_data_valid, 1'b0);
        end
        run_one(b4(8'h30), 8'h30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
